// File: rtl/fll_cfg_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fll_cfg_responder_pkg
//  Description : Shared definitions for the FLL configuration responder:
//                register addresses, CFG1 field positions, and the state
//                encodings of the handshake and lock-emulation FSMs.
//  Revision    : 1.0 - initial release
// ============================================================================
package fll_cfg_responder_pkg;

    // Register map (2-bit address space)
    localparam logic [1:0] ADDR_STATUS = 2'd0;   // read-only
    localparam logic [1:0] ADDR_CFG1   = 2'd1;   // read/write
    localparam logic [1:0] ADDR_CFG2   = 2'd2;   // read/write
    localparam logic [1:0] ADDR_INTEG  = 2'd3;   // read-only

    // CFG1 field layout
    localparam int MULT_LSB   = 0;
    localparam int MULT_W     = 16;
    localparam int DIV_LSB    = 26;
    localparam int DIV_W      = 4;
    localparam int BYPASS_BIT = 31;

    // Request/acknowledge handshake states
    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_ACK      = 2'd1,
        HS_WAIT_LOW = 2'd2
    } hs_state_e;

    // Lock emulation states
    typedef enum logic [0:0] {
        LK_UNLOCKED = 1'b0,
        LK_LOCKED   = 1'b1
    } lock_state_e;

    // STATUS word: lock flag in the MSB, active multiplier in the low half.
    function automatic logic [31:0] status_word(input logic lock, input logic [15:0] mult);
        return {lock, 15'b0, mult};
    endfunction

endpackage : fll_cfg_responder_pkg
`default_nettype wire

// File: rtl/fll_cfg_responder_lock_emu.sv
`default_nettype none
// ============================================================================
//  Module      : fll_lock_emu
//  Description : Lock-settle emulation. After every restart a counter runs
//                up from zero; once it reaches the programmed threshold the
//                block reports lock and freezes the counter until the next
//                restart.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i        in   clock, rising edge
//    rstn_i       in   asynchronous active-low reset
//    restart_i    in   one-cycle strobe: clear counter, drop lock
//    threshold_i  in   lock threshold (compared as counter >= threshold)
//    locked_o     out  1 while in LOCKED
//    count_o      out  current settle counter value
// ============================================================================
module fll_lock_emu
    import fll_cfg_responder_pkg::*;
#(
    parameter int LOCK_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  restart_i,
    input  logic [LOCK_CNT_W-1:0] threshold_i,
    output logic                  locked_o,
    output logic [LOCK_CNT_W-1:0] count_o
);

    localparam logic [LOCK_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LOCK_CNT_W-1:0] CNT_ONE = LOCK_CNT_W'(1);

    lock_state_e           state_q, state_d;
    logic [LOCK_CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= LK_UNLOCKED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (restart_i) begin
            // A restart wins over everything, even if already locked.
            state_d = LK_UNLOCKED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LK_UNLOCKED: begin
                    // The counter does not advance on the locking edge, so
                    // once locked it reads exactly the threshold value.
                    if (cnt_q >= threshold_i) begin
                        state_d = LK_LOCKED;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                LK_LOCKED: begin
                    state_d = LK_LOCKED;
                end
                default: begin
                    state_d = LK_UNLOCKED;
                end
            endcase
        end
    end

    assign locked_o = (state_q == LK_LOCKED);
    assign count_o  = cnt_q;

endmodule : fll_lock_emu
`default_nettype wire

// File: rtl/fll_cfg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : fll_cfg_responder
//  Description : Register responder for an FLL configuration port. Serves a
//                4-phase req/ack handshake onto a four-entry register map
//                (STATUS, CFG1, CFG2, INTEG) and drives the active FLL
//                settings plus an emulated lock indication.
//  Revision    : 1.0 - initial release
//
//  Parameters
//    LOCK_CNT_W   settle counter width (1..32)
//    CFG1_RST     reset value of CFG1
//    CFG2_RST     reset value of CFG2
//
//  Ports
//    clk_i         in   clock, rising edge
//    rstn_i        in   asynchronous active-low reset
//    fll_req_i     in   request level from initiator
//    fll_wrn_i     in   0 = write, 1 = read
//    fll_add_i     in   register address
//    fll_data_i    in   write data
//    fll_ack_o     out  one-cycle acknowledge
//    fll_r_data_o  out  read data, non-zero only while acknowledging a read
//    fll_lock_o    out  lock indication (forced high by CFG1 bypass bit)
//    mult_o        out  active multiplication factor, CFG1[15:0]
//    div_o         out  active divider, CFG1[29:26]
// ============================================================================
module fll_cfg_responder
    import fll_cfg_responder_pkg::*;
#(
    parameter int          LOCK_CNT_W = 16,
    parameter logic [31:0] CFG1_RST   = 32'h0000_05F5,
    parameter logic [31:0] CFG2_RST   = 32'h0000_0010
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        fll_req_i,
    input  logic        fll_wrn_i,
    input  logic [1:0]  fll_add_i,
    input  logic [31:0] fll_data_i,
    output logic        fll_ack_o,
    output logic [31:0] fll_r_data_o,
    output logic        fll_lock_o,
    output logic [15:0] mult_o,
    output logic [3:0]  div_o
);

    hs_state_e             hs_state_q, hs_state_d;
    logic [31:0]           r_data_q,   r_data_d;
    logic [31:0]           cfg1_q,     cfg1_d;
    logic [31:0]           cfg2_q,     cfg2_d;

    logic                  cfg1_wr;
    logic                  emu_locked;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic [31:0]           rd_value;

    // ------------------------------------------------------------------
    // State and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hs_state_q <= HS_IDLE;
            r_data_q   <= '0;
            cfg1_q     <= CFG1_RST;
            cfg2_q     <= CFG2_RST;
        end else begin
            hs_state_q <= hs_state_d;
            r_data_q   <= r_data_d;
            cfg1_q     <= cfg1_d;
            cfg2_q     <= cfg2_d;
        end
    end

    // Read multiplexer, evaluated against the register values present at
    // the sampling edge.
    always_comb begin
        rd_value = '0;
        case (fll_add_i)
            ADDR_STATUS: rd_value = status_word(fll_lock_o, mult_o);
            ADDR_CFG1:   rd_value = cfg1_q;
            ADDR_CFG2:   rd_value = cfg2_q;
            ADDR_INTEG:  rd_value = 32'(lock_cnt);
            default:     rd_value = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake FSM. The access is performed on the IDLE->ACK edge, so the
    // register update and the read data both become visible together with
    // the acknowledge. Read data is only loaded on that edge and defaults
    // to zero otherwise, which clears it again as ACK is left.
    // ------------------------------------------------------------------
    always_comb begin
        hs_state_d = hs_state_q;
        r_data_d   = '0;
        cfg1_d     = cfg1_q;
        cfg2_d     = cfg2_q;
        cfg1_wr    = 1'b0;
        case (hs_state_q)
            HS_IDLE: begin
                if (fll_req_i) begin
                    hs_state_d = HS_ACK;
                    if (fll_wrn_i) begin
                        r_data_d = rd_value;
                    end else begin
                        case (fll_add_i)
                            ADDR_CFG1: begin
                                cfg1_d  = fll_data_i;
                                cfg1_wr = 1'b1;
                            end
                            ADDR_CFG2: cfg2_d = fll_data_i;
                            default: begin
                                // STATUS and INTEG are read-only; the write
                                // is acknowledged and dropped.
                            end
                        endcase
                    end
                end
            end
            HS_ACK: begin
                hs_state_d = HS_WAIT_LOW;
            end
            HS_WAIT_LOW: begin
                // Requests stay blocked until the initiator drops req, so a
                // held req can never trigger a second access.
                if (!fll_req_i) begin
                    hs_state_d = HS_IDLE;
                end
            end
            default: begin
                hs_state_d = HS_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lock emulation. The CFG1 write strobe restarts it on the same edge
    // that loads CFG1, so the cleared counter and dropped lock are seen in
    // the cycle following the access. Any CFG1 write restarts, even one
    // that leaves the value unchanged.
    // ------------------------------------------------------------------
    fll_lock_emu #(
        .LOCK_CNT_W (LOCK_CNT_W)
    ) u_lock_emu (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .restart_i   (cfg1_wr),
        .threshold_i (cfg2_q[LOCK_CNT_W-1:0]),
        .locked_o    (emu_locked),
        .count_o     (lock_cnt)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fll_ack_o    = (hs_state_q == HS_ACK);
    assign fll_r_data_o = r_data_q;
    // Bypass overrides the emulated lock without touching the lock FSM.
    assign fll_lock_o   = emu_locked | cfg1_q[BYPASS_BIT];
    assign mult_o       = cfg1_q[MULT_LSB +: MULT_W];
    assign div_o        = cfg1_q[DIV_LSB +: DIV_W];

endmodule : fll_cfg_responder
`default_nettype wire
